ov_write: RTL and testbench
===========================

# ov_write

Write-side controller for the OV7670 + AL422B camera FIFO module. It is the counterpart of the FIFO read engine.
- Watches the camera's VSYNC/HREF, resets the FIFO write pointer between frames and enables FIFO writes for exactly one frame.
- Checks the captured line count, then hands the frozen frame to the reader over the `new_frame`/`frame_read` handshake.
- Sits between the camera pins and the FIFO read engine, in the 25 MHz system domain.

## Interface
Parameters:
- `FRAME_LINES`, 240: HREF pulses expected per frame (QVGA).
- `WRST_CYCLES`, 8: clocks that `wrst` is held low, at least 320 ns at 25 MHz.
- `LINE_W`, 9: width of the line counter.

Ports:
- `clk_25MHz` in 1: system clock. The block has exactly one clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `initialized` in 1: camera SCCB configuration done. Capture is gated by it.
- `vsync` in 1: camera VSYNC, asynchronous, active-high between frames.
- `href` in 1: camera HREF, asynchronous, high during each active line.
- `wen` out 1: FIFO write enable, active-high. It is ANDed with HREF on the camera board.
- `wrst` out 1: FIFO write-pointer reset, active-low.
- `new_frame` out 1: a complete frame is in the FIFO. Level signal, held until accepted.
- `frame_read` in 1: reader status. Idles high, goes low while reading, returns high when done.
- `frame_error` out 1: one-cycle pulse when a frame had the wrong line count.
- `line_count` out `LINE_W`: lines counted in the last completed capture.

## Operation
- `vsync` and `href` each pass through a 2-flop synchronizer plus a registered edge detector.
- The FSM is registered, with one-hot or binary encoding taken from the package. States and transitions:
  - **IDLE**: `wen`=0, `wrst`=1. Go to ARM when `initialized`=1.
  - **ARM**: wait for the VSYNC rising edge. On it, set `wrst`<=0, load the hold counter with `WRST_CYCLES`-1 and go to WRST.
  - **WRST**: count down. At 0, set `wrst`<=1 and go to WAIT_VS.
  - **WAIT_VS**: wait for the VSYNC falling edge. On it, set `wen`<=1, clear the line counter and go to CAPTURE.
  - **CAPTURE**: each HREF rising edge increments the line counter, saturating at all-ones. On the VSYNC rising edge, set `wen`<=0 and latch `line_count`.
    - If count == `FRAME_LINES`: set `new_frame`<=1 and go to HANDOFF.
    - Otherwise: pulse `frame_error`, drive `wrst`<=0 immediately (this edge counts as the ARM edge) and go to WRST.
  - **HANDOFF**: wait for `frame_read`=0. Then set `new_frame`<=0 and go to DRAIN.
  - **DRAIN**: wait for `frame_read`=1, then go to ARM.
- Camera frames arriving during HANDOFF or DRAIN are dropped, because `wen` stays 0 so the FIFO contents stay frozen.
- `initialized`=0 in any state forces IDLE on the next edge. `wen` goes to 0, `wrst` to 1 and `new_frame` to 0; `line_count` is kept.
- In WRST, VSYNC and HREF edges are ignored. In WAIT_VS and HANDOFF, HREF edges are ignored.
- A VSYNC rising edge and an HREF rising edge in the same CAPTURE cycle: the VSYNC edge wins and the HREF edge is not counted.

## Timing
- Reset (`rst_n`=0 at a clock edge) puts every output at its reset value on that edge, including in mid-capture:
  - `wen`=0, `wrst`=1, `new_frame`=0, `frame_error`=0, `line_count`=0.
  - FSM goes to IDLE.
- Synchronizer latency: a raw pin edge is seen as an edge pulse 3 clocks later. All FSM actions on it are registered, so the output changes 4 clocks after the pin edge.
- `wrst` is low for exactly `WRST_CYCLES` clocks.
- `wen` rises 4 clocks after the VSYNC falling edge and falls 4 clocks after the next VSYNC rising edge. VSYNC back porch (≥ 17 lines) covers this margin.
- `new_frame` rises in the same cycle that `wen` falls on a good frame. It falls 1 clock after `frame_read` is sampled low.
- HREF pulses must be ≥ 3 clocks high and ≥ 3 clocks low to be counted. OV7670 line timing satisfies this by a large margin.

## Structure
- Package `ov_pkg` holds:
  - the FSM state typedef;
  - `FRAME_LINES_QVGA`=240 and `WRST_CYCLES_DEF`=8;
  - `FRAME_BYTES_QVGA`=153600, shared with the reader.
- Sub-module `sync_edge`: 2-flop synchronizer plus rise/fall pulse outputs. It is instantiated once for `vsync` and once for `href`.

## Test plan
- Good frame: `initialized`=1, VSYNC pulse, then 240 HREF pulses, then VSYNC → check:
  - `wrst` low for exactly 8 clocks;
  - `wen` high only during the frame;
  - `new_frame`=1 and `line_count`=240.
- Handoff: after `new_frame`, drive `frame_read` 1→0 → `new_frame` falls 1 clock later. Then drive `frame_read` 0→1 → FSM returns to ARM.
  - Two camera frames sent during the low phase leave `wen`=0 throughout.
- Short frame: 239 HREF pulses → one-cycle `frame_error`, `line_count`=239, `new_frame` stays 0.
  - `wrst` goes low in the same cycle `wen` falls, and the next good frame is captured.
- Simultaneous edges: HREF and VSYNC rising edges in the same cycle at the end of a 240-line frame → count stays 240 and `new_frame`=1.
- Reset mid-capture at line 100 → on that edge `wen`=0, `wrst`=1, `new_frame`=0, `line_count`=0. After release, the next VSYNC starts a clean capture.
- `initialized` dropped in HANDOFF → IDLE next edge with `new_frame`=0. Re-asserting `initialized` goes to ARM.

Source files
------------

// File: rtl/ov_pkg.sv
// rtl/ov_pkg.sv - shared types and constants for the OV7670 FIFO write/read engines
package ov_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WRST    = 3'd2,
    ST_WAIT_VS = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_HANDOFF = 3'd5,
    ST_DRAIN   = 3'd6
  } ov_state_t;

  localparam int FRAME_LINES_QVGA = 240;
  localparam int WRST_CYCLES_DEF  = 8;
  localparam int FRAME_BYTES_QVGA = 153600;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-flop synchronizer with registered rise/fall pulses
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  // synchronize the pin, then compare against the previous synced level
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/ov_write.sv
// rtl/ov_write.sv - camera-side FIFO write controller with frame handoff to the reader
module ov_write
  import ov_pkg::*;
#(
  parameter int FRAME_LINES = FRAME_LINES_QVGA,
  parameter int WRST_CYCLES = WRST_CYCLES_DEF,
  parameter int LINE_W      = 9
) (
  input  logic              clk_25MHz,
  input  logic              rst_n,
  input  logic              initialized,
  input  logic              vsync,
  input  logic              href,
  output logic              wen,
  output logic              wrst,
  output logic              new_frame,
  input  logic              frame_read,
  output logic              frame_error,
  output logic [LINE_W-1:0] line_count
);

  localparam int HOLD_W = $clog2(WRST_CYCLES + 1);

  logic w_vs_rise;
  logic w_vs_fall;
  logic w_href_rise;
  logic w_href_fall_unused;

  ov_state_t         r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [LINE_W-1:0] r_lines;
  logic              r_wen;
  logic              r_wrst;
  logic              r_new_frame;
  logic              r_frame_error;
  logic [LINE_W-1:0] r_line_count;

  sync_edge u_vs_sync (
    .i_clk   (clk_25MHz),
    .i_rst_n (rst_n),
    .i_async (vsync),
    .o_rise  (w_vs_rise),
    .o_fall  (w_vs_fall)
  );

  sync_edge u_href_sync (
    .i_clk   (clk_25MHz),
    .i_rst_n (rst_n),
    .i_async (href),
    .o_rise  (w_href_rise),
    .o_fall  (w_href_fall_unused)
  );

  // frame FSM: arm, reset the write pointer, capture one frame, hand it to the reader
  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_hold        <= '0;
      r_lines       <= '0;
      r_wen         <= 1'b0;
      r_wrst        <= 1'b1;
      r_new_frame   <= 1'b0;
      r_frame_error <= 1'b0;
      r_line_count  <= '0;
    end else begin
      r_frame_error <= 1'b0;
      if (!initialized) begin
        // losing the sensor config abandons whatever is in flight; the last count is kept
        r_state     <= ST_IDLE;
        r_wen       <= 1'b0;
        r_wrst      <= 1'b1;
        r_new_frame <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_wen   <= 1'b0;
            r_wrst  <= 1'b1;
            r_state <= ST_ARM;
          end
          ST_ARM: begin
            if (w_vs_rise) begin
              r_wrst  <= 1'b0;
              r_hold  <= HOLD_W'(WRST_CYCLES - 1);
              r_state <= ST_WRST;
            end
          end
          ST_WRST: begin
            if (r_hold == '0) begin
              r_wrst  <= 1'b1;
              r_state <= ST_WAIT_VS;
            end else begin
              r_hold <= r_hold - HOLD_W'(1);
            end
          end
          ST_WAIT_VS: begin
            if (w_vs_fall) begin
              r_wen   <= 1'b1;
              r_lines <= '0;
              r_state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (w_vs_rise) begin
              r_wen        <= 1'b0;
              r_line_count <= r_lines;
              if (r_lines == LINE_W'(FRAME_LINES)) begin
                r_new_frame <= 1'b1;
                r_state     <= ST_HANDOFF;
              end else begin
                // this VSYNC edge doubles as the arming edge for the retry
                r_frame_error <= 1'b1;
                r_wrst        <= 1'b0;
                r_hold        <= HOLD_W'(WRST_CYCLES - 1);
                r_state       <= ST_WRST;
              end
            end else if (w_href_rise && (r_lines != '1)) begin
              r_lines <= r_lines + LINE_W'(1);
            end
          end
          ST_HANDOFF: begin
            if (!frame_read) begin
              r_new_frame <= 1'b0;
              r_state     <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (frame_read) begin
              r_state <= ST_ARM;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign wen         = r_wen;
  assign wrst        = r_wrst;
  assign new_frame   = r_new_frame;
  assign frame_error = r_frame_error;
  assign line_count  = r_line_count;

endmodule

// File: tb/tb_ov_write.sv
// tb/tb_ov_write.sv - directed scoreboard bench for ov_write
module tb_ov_write;

  logic       clk_25MHz = 1'b0;
  logic       rst_n;
  logic       initialized;
  logic       vsync;
  logic       href;
  logic       wen;
  logic       wrst;
  logic       new_frame;
  logic       frame_read;
  logic       frame_error;
  logic [8:0] line_count;

  typedef struct {
    logic err;
    int   lines;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  int wen_hi, wrst_lo, wrst_first, nf_first, err_cnt, err_tick;
  int wen_first, wen_lo_lines, wen_total;
  logic href_with_vs = 1'b0;
  logic nf_prev = 1'b0;

  ov_write #(.FRAME_LINES(240), .WRST_CYCLES(8), .LINE_W(9)) dut (
    .clk_25MHz   (clk_25MHz),
    .rst_n       (rst_n),
    .initialized (initialized),
    .vsync       (vsync),
    .href        (href),
    .wen         (wen),
    .wrst        (wrst),
    .new_frame   (new_frame),
    .frame_read  (frame_read),
    .frame_error (frame_error),
    .line_count  (line_count)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25MHz);
  endtask

  task automatic push(input logic err, input int lines);
    exp_t e;
    e.err   = err;
    e.lines = lines;
    sb.push_back(e);
  endtask

  // scoreboard: every completed capture (good or bad) pops one expectation
  always @(negedge clk_25MHz) begin
    if (frame_error || (new_frame && !nf_prev)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_err", frame_error, e.err);
        chk("sb_lines", line_count, e.lines);
      end
    end
    nf_prev = new_frame;
  end

  task automatic vs_high_phase();
    wen_hi = 0; wrst_lo = 0; wrst_first = 0; nf_first = 0; err_cnt = 0; err_tick = 0;
    vsync = 1'b1;
    if (href_with_vs) href = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_25MHz);
      if (wen) wen_hi++;
      if (!wrst) begin
        wrst_lo++;
        if (wrst_first == 0) wrst_first = k;
      end
      if (new_frame && nf_first == 0) nf_first = k;
      if (frame_error) begin
        err_cnt++;
        err_tick = k;
      end
      if (wen) wen_total++;
      if (k == 4) href = 1'b0;
    end
  endtask

  task automatic bp_phase();
    wen_first = 0;
    vsync = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_25MHz);
      if (wen && wen_first == 0) wen_first = k;
      if (wen) wen_total++;
    end
  endtask

  task automatic lines(input int n);
    wen_lo_lines = 0;
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (k == 4) href = 1'b0;
        @(negedge clk_25MHz);
        if (!wen) wen_lo_lines++;
        if (wen) wen_total++;
      end
    end
  endtask

  task automatic frame(input int n);
    vs_high_phase();
    bp_phase();
    lines(n);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_25MHz);
      if (wen) wen_total++;
    end
  endtask

  task automatic close_frame();
    vs_high_phase();
    vsync = 1'b0;
    tick(20);
  endtask

  task automatic release_reader();
    frame_read = 1'b0;
    tick(2);
    frame_read = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0; initialized = 1'b0; vsync = 1'b0; href = 1'b0; frame_read = 1'b1;
    tick(3);
    chk("rst_wen", wen, 1'b0);
    chk("rst_wrst", wrst, 1'b1);
    chk("rst_new_frame", new_frame, 1'b0);
    chk("rst_frame_error", frame_error, 1'b0);
    chk("rst_line_count", line_count, 9'd0);
    rst_n = 1'b1;
    tick(2);

    vs_high_phase();
    chk("noinit_wrst", wrst_lo, 0);
    vsync = 1'b0;
    tick(20);
    initialized = 1'b1;
    tick(2);

    push(1'b0, 240);
    frame(240);
    chk("good_wrst_lat", wrst_first, 4);
    chk("good_wrst_width", wrst_lo, 8);
    chk("good_wen_during_arm", wen_hi, 0);
    chk("good_wen_rise", wen_first, 4);
    chk("good_wen_in_lines", wen_lo_lines, 0);
    close_frame();
    chk("good_wen_fall", wen_hi, 3);
    chk("good_nf_rise", nf_first, 4);
    chk("good_line_count", line_count, 9'd240);
    chk("good_wen_after", wen, 1'b0);

    chk("handoff_nf_held", new_frame, 1'b1);
    frame_read = 1'b0;
    tick(1);
    chk("handoff_nf_fall", new_frame, 1'b0);
    wen_total = 0;
    frame(240);
    frame(240);
    chk("drop_wen_total", wen_total, 0);
    frame_read = 1'b1;
    tick(2);

    push(1'b1, 239);
    frame(239);
    chk("short_wen_rise", wen_first, 4);
    push(1'b0, 240);
    frame(240);
    chk("short_err_count", err_cnt, 1);
    chk("short_err_tick", err_tick, 4);
    chk("short_wrst_lat", wrst_first, 4);
    chk("short_wen_fall", wen_hi, 3);
    chk("short_wrst_width", wrst_lo, 8);
    chk("short_no_nf", nf_first, 0);
    chk("short_line_count", line_count, 9'd239);
    chk("retry_wen_rise", wen_first, 4);
    close_frame();
    chk("retry_nf_rise", nf_first, 4);
    chk("retry_line_count", line_count, 9'd240);
    release_reader();

    push(1'b0, 240);
    frame(240);
    href_with_vs = 1'b1;
    close_frame();
    href_with_vs = 1'b0;
    chk("simul_nf_rise", nf_first, 4);
    chk("simul_line_count", line_count, 9'd240);
    release_reader();

    vs_high_phase();
    bp_phase();
    lines(100);
    chk("midcap_wen_before", wen, 1'b1);
    rst_n = 1'b0;
    tick(1);
    chk("midcap_rst_wen", wen, 1'b0);
    chk("midcap_rst_wrst", wrst, 1'b1);
    chk("midcap_rst_nf", new_frame, 1'b0);
    chk("midcap_rst_line_count", line_count, 9'd0);
    rst_n = 1'b1;
    tick(3);
    push(1'b0, 240);
    frame(240);
    chk("postrst_wrst_width", wrst_lo, 8);
    close_frame();
    chk("postrst_nf_rise", nf_first, 4);

    chk("init_nf_before", new_frame, 1'b1);
    initialized = 1'b0;
    tick(1);
    chk("init_drop_nf", new_frame, 1'b0);
    chk("init_drop_wen", wen, 1'b0);
    chk("init_drop_wrst", wrst, 1'b1);
    chk("init_drop_line_count", line_count, 9'd240);
    initialized = 1'b1;
    tick(2);
    push(1'b0, 240);
    frame(240);
    chk("rearm_wrst_width", wrst_lo, 8);
    close_frame();
    chk("rearm_nf_rise", nf_first, 4);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
